// File: rtl/cdc_pkg.sv
// Shared constants and helpers for the read side of the dual-clock FIFO.
package cdc_pkg;

    localparam int FIFO_READ_LATENCY  = 1;
    localparam int DEFAULT_DATA_WIDTH = 8;

    // Occupancy needs one bit more than the pointers so that "full" (== DEPTH) is representable.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/stream_skid_buffer.sv
// DEPTH-entry register ring holding words captured from the FIFO until the consumer takes them.
module stream_skid_buffer
    import cdc_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          push,
    input  logic [DATA_WIDTH-1:0]         push_data,
    input  logic                          pop,
    output logic [DATA_WIDTH-1:0]         head_data,
    output logic [level_width(DEPTH)-1:0] occ
);

    localparam int PW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;

    // Flush wins over any push/pop in the same cycle; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   occ <= occ + level_width(DEPTH)'(1);
                2'b01:   occ <= occ - level_width(DEPTH)'(1);
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side controller: issues credit-limited FIFO reads and streams the returned words out via valid/ready.
module fifo_stream_reader
    import cdc_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int DEPTH       = 4,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_WIDTH-1:0]         i_Fifo_Data,
    input  logic                          i_Fifo_Empty,
    output logic                          o_Fifo_Read_Enable,
    input  logic                          i_Flush,
    output logic [DATA_WIDTH-1:0]         o_Output_Data,
    output logic                          o_Data_Valid,
    input  logic                          i_Ready,
    output logic [level_width(DEPTH)-1:0] o_Level,
    output logic [COUNT_WIDTH-1:0]        o_Word_Count
);

    localparam int LW = level_width(DEPTH);
    localparam int SW = LW + 1;

    logic [FIFO_READ_LATENCY-1:0] inflight_pipe;
    logic [LW-1:0]                occ;
    logic [SW-1:0]                outstanding;
    logic                         push;
    logic                         pop;

    // Words already buffered plus words still coming back from the FIFO must fit in the buffer,
    // so a read is only issued when a slot is guaranteed; i_Ready never feeds this path.
    assign outstanding        = SW'(occ) + SW'($countones(inflight_pipe));
    assign o_Fifo_Read_Enable = !reset && !i_Fifo_Empty && !i_Flush && (outstanding < SW'(DEPTH));

    assign push = inflight_pipe[FIFO_READ_LATENCY-1] && !i_Flush;

    // Stream handshake: a word transfers on every cycle where o_Data_Valid and i_Ready are both high;
    // while valid is high and ready is low, data and valid hold until the transfer or a flush.
    assign o_Data_Valid = (occ != '0) && !i_Flush;
    assign pop          = o_Data_Valid && i_Ready;
    assign o_Level      = occ;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight_pipe <= '0;
            o_Word_Count  <= '0;
        end else begin
            if (i_Flush) begin
                inflight_pipe <= '0;
            end else begin
                inflight_pipe[0] <= o_Fifo_Read_Enable;
                for (int i = 1; i < FIFO_READ_LATENCY; i++) begin
                    inflight_pipe[i] <= inflight_pipe[i-1];
                end
            end
            if (pop) begin
                o_Word_Count <= o_Word_Count + COUNT_WIDTH'(1);
            end
        end
    end

    stream_skid_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .flush     (i_Flush),
        .push      (push),
        .push_data (i_Fifo_Data),
        .pop       (pop),
        .head_data (o_Output_Data),
        .occ       (occ)
    );

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: behavioural FIFO, scoreboard on the output stream, directed and random phases.
module tb_fifo_stream_reader;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int CW    = 4;
    localparam int LW    = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [DW-1:0] fifo_data = '0;
    logic          fifo_empty;
    logic          rd_en;
    logic          flush;
    logic [DW-1:0] out_data;
    logic          valid;
    logic          ready;
    logic [LW-1:0] level;
    logic [CW-1:0] word_count;

    fifo_stream_reader #(
        .DATA_WIDTH  (DW),
        .DEPTH       (DEPTH),
        .COUNT_WIDTH (CW)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .i_Fifo_Data        (fifo_data),
        .i_Fifo_Empty       (fifo_empty),
        .o_Fifo_Read_Enable (rd_en),
        .i_Flush            (flush),
        .o_Output_Data      (out_data),
        .o_Data_Valid       (valid),
        .i_Ready            (ready),
        .o_Level            (level),
        .o_Word_Count       (word_count)
    );

    // ---------------- scoreboard state ----------------
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    int            errors = 0;
    int            checks = 0;
    int            pops = 0;
    logic [CW-1:0] cnt_model = '0;
    logic          hold_prev = 1'b0;
    logic [DW-1:0] hold_data = '0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // ---------------- FIFO model: data one cycle after the read strobe ----------------
    always @(posedge clk) begin
        if (rd_en) begin
            if (fifo_q.size() > 0) begin
                fifo_data <= fifo_q.pop_front();
            end else begin
                check("read_when_empty", 32'(rd_en), 32'd0);
            end
        end
    end

    always @(negedge clk) begin
        fifo_empty = (fifo_q.size() == 0);
    end

    // ---------------- output monitor ----------------
    always @(negedge clk) begin
        if (reset) begin
            cnt_model = '0;
            pops      = 0;
            hold_prev = 1'b0;
        end else begin
            check("level_le_depth", 32'(level <= LW'(DEPTH)), 32'd1);
            check("word_count", 32'(word_count), 32'(cnt_model));
            if (hold_prev && !flush) begin
                check("hold_valid", 32'(valid), 32'd1);
                check("hold_data", 32'(out_data), 32'(hold_data));
            end
            if (valid && ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    check("stream_data", 32'(out_data), 32'(exp_q.pop_front()));
                end
                cnt_model = cnt_model + CW'(1);
                pops++;
            end
            hold_prev = valid && !ready;
            hold_data = out_data;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic at_mid();
        @(negedge clk);
        #1;
    endtask

    task automatic load_word(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) begin
            next_cycle();
        end
        check({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_first(input string tag, input logic [DW-1:0] w);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            at_mid();
            if (valid) begin
                check(tag, 32'(out_data), 32'(w));
                found = 1'b1;
                break;
            end
        end
        check({tag, "_seen"}, 32'(found), 32'd1);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_rd_en"}, 32'(rd_en), 32'd0);
        check({tag, "_valid"}, 32'(valid), 32'd0);
        check({tag, "_level"}, 32'(level), 32'd0);
        check({tag, "_count"}, 32'(word_count), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        int rd_count;
        int sent;

        reset      = 1'b1;
        flush      = 1'b0;
        ready      = 1'b0;
        fifo_empty = 1'b1;
        repeat (2) next_cycle();
        check_cleared("reset");
        reset = 1'b0;
        next_cycle();

        // Preloaded stream with ready held high: valid from cycle 2, one word per cycle.
        ready = 1'b1;
        for (int i = 1; i <= 10; i++) load_word(DW'(i));
        for (int c = 0; c <= 12; c++) begin
            at_mid();
            if (c == 0) check("t1_first_rd_en", 32'(rd_en), 32'd1);
            check("t1_valid", 32'(valid), 32'(c >= 2 && c <= 11));
            if (c >= 2 && c <= 11) check("t1_data", 32'(out_data), 32'(c - 1));
            next_cycle();
        end
        check("t1_word_count", 32'(word_count), 32'd10);

        // Backpressure: credit stops at DEPTH reads, output holds, then six words back to back.
        ready = 1'b0;
        for (int i = 1; i <= 6; i++) load_word(DW'(i));
        rd_count = 0;
        for (int c = 0; c < 10; c++) begin
            at_mid();
            if (rd_en) rd_count++;
            next_cycle();
        end
        at_mid();
        check("t2_reads", 32'(rd_count), 32'd4);
        check("t2_level", 32'(level), 32'd4);
        check("t2_rd_en", 32'(rd_en), 32'd0);
        check("t2_valid", 32'(valid), 32'd1);
        check("t2_head", 32'(out_data), 32'h01);
        next_cycle();
        ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            at_mid();
            check("t2_burst_valid", 32'(valid), 32'd1);
            check("t2_burst_data", 32'(out_data), 32'(k + 1));
            next_cycle();
        end

        // Random ready against a trickle-fed FIFO.
        sent = 0;
        for (int cyc = 0; cyc < 20000 && !(sent == 1000 && exp_q.size() == 0); cyc++) begin
            ready = 1'($urandom_range(0, 1));
            if (sent < 1000 && fifo_q.size() < 6 && $urandom_range(0, 3) != 0) begin
                load_word(DW'($urandom_range(0, 255)));
                sent++;
            end
            next_cycle();
        end
        check("t3_all_delivered", 32'(sent == 1000 && exp_q.size() == 0), 32'd1);
        ready = 1'b1;
        repeat (3) next_cycle();

        // Flush with three buffered words and one in flight.
        ready = 1'b0;
        for (int i = 0; i < 10; i++) load_word(DW'(8'h30 + i));
        repeat (4) next_cycle();
        check("t4_level_before", 32'(level), 32'd3);
        check("t4_rd_en_full", 32'(rd_en), 32'd0);
        flush = 1'b1;
        ready = 1'b1;
        at_mid();
        check("t4_flush_valid", 32'(valid), 32'd0);
        check("t4_flush_rd_en", 32'(rd_en), 32'd0);
        next_cycle();
        flush = 1'b0;
        repeat (4) void'(exp_q.pop_front());
        check("t4_level_after", 32'(level), 32'd0);
        at_mid();
        check("t4_rd_en_resume", 32'(rd_en), 32'd1);
        wait_first("t4_next_word", 8'h34);
        wait_drain("t4");

        // Asynchronous reset with two buffered words and one in flight.
        ready = 1'b0;
        for (int i = 0; i < 10; i++) load_word(DW'(8'h50 + i));
        repeat (3) next_cycle();
        check("t5_level_before", 32'(level), 32'd2);
        reset = 1'b1;
        #1;
        check_cleared("t5_reset");
        fifo_q.delete();
        exp_q.delete();
        fifo_empty = 1'b1;
        repeat (2) next_cycle();
        reset = 1'b0;
        ready = 1'b1;
        load_word(8'hA5);
        wait_first("t5_first_word", 8'hA5);
        wait_drain("t5");

        // Counter wrap at 2^CW pops.
        reset = 1'b1;
        repeat (2) next_cycle();
        reset = 1'b0;
        ready = 1'b1;
        for (int i = 0; i < 17; i++) load_word(DW'(8'h70 + i));
        for (int i = 0; i < 100 && pops < 16; i++) next_cycle();
        check("t6_pops16", 32'(pops), 32'd16);
        check("t6_count_wrap", 32'(word_count), 32'd0);
        for (int i = 0; i < 100 && pops < 17; i++) next_cycle();
        check("t6_pops17", 32'(pops), 32'd17);
        check("t6_count_after", 32'(word_count), 32'd1);
        wait_drain("t6");

        // ---------------- final report ----------------
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
